// File: rtl/pipe_elastic.sv
// Multi-lane elastic pipe buffer with per-beat lane compaction and flush.
// Define PIPE_BYPASS_EN for a zero-latency path when the buffer is empty.
module pipe_elastic #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_lane_vld,
  input  logic [LANES*WIDTH-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           out_lane_vld,
  output logic [LANES*WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [LANES-1:0]       mem_vld  [DEPTH];
  logic [LANES*WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;
  logic [LANES-1:0]       cmp_vld;
  logic [LANES*WIDTH-1:0] cmp_data;
  logic                   any_lane;
  logic                   byp;
  logic                   push;
  logic                   wr_en;
  logic                   rd_en;
  logic                   empty;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Shift valid lanes toward lane 0; mask becomes a thermometer code.
  always_comb begin
    int k;
    cmp_data = '0;
    cmp_vld  = '0;
    k        = 0;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane_vld[i]) begin
        cmp_data[k*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
        k = k + 1;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      cmp_vld[i] = (i < k);
    end
  end

  assign empty    = (count == '0);
  assign any_lane = |in_lane_vld;
  assign in_ready = (count < FULL);

`ifdef PIPE_BYPASS_EN
  assign byp = empty && !flush && in_valid && any_lane;
`else
  assign byp = 1'b0;
`endif

  assign push      = in_valid && in_ready && any_lane && !flush;
  assign wr_en     = push && !(byp && out_ready);
  assign rd_en     = !empty && out_ready && !flush;
  assign out_valid = !empty || byp;
  assign occupancy = count;

  always_comb begin
    out_lane_vld = '0;
    out_data     = '0;
    if (!empty) begin
      out_lane_vld = mem_vld[rd_ptr];
      out_data     = mem_data[rd_ptr];
    end else if (byp) begin
      out_lane_vld = cmp_vld;
      out_data     = cmp_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Payload storage needs no reset; outputs are gated by count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_vld[wr_ptr]  <= cmp_vld;
      mem_data[wr_ptr] <= cmp_data;
    end
  end

endmodule
